// File: rtl/wifi_shared_mem_ctrl_if.sv
// Bus bundle between the AHB register slice / shared_mem_top and the
// WiFi shared-memory sequencer.
interface wifi_shared_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tx_start;
    logic                  rx_start;
    logic                  abort;
    logic [DATA_WIDTH-1:0] data_size;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ahb_wr;
    logic                  chain_we;
    logic                  mode;
    logic                  chain_re;
    logic                  tx_irq;
    logic                  rx_irq;
    logic                  busy;
    logic                  err;
    logic [DATA_WIDTH-1:0] word_cnt;
    logic [2:0]            state;

    modport master (
        output tx_start, rx_start, abort, data_size,
        output fifo_full, fifo_empty, ahb_wr, chain_we,
        input  mode, chain_re, tx_irq, rx_irq,
        input  busy, err, word_cnt, state
    );

    modport slave (
        input  tx_start, rx_start, abort, data_size,
        input  fifo_full, fifo_empty, ahb_wr, chain_we,
        output mode, chain_re, tx_irq, rx_irq,
        output busy, err, word_cnt, state
    );
endinterface

// File: rtl/wifi_shared_mem_ctrl.sv
// WiFi shared-memory FIFO sequencer: mode select, guard gap, word counting.
// Optional no-progress timeout enabled by defining WIFI_CTRL_TIMEOUT_EN.
module wifi_shared_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  hclk,
    input  logic                  reset,
    wifi_shared_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GUARD      = 3'd1,
        TX_LOAD    = 3'd2,
        TX_STREAM  = 3'd3,
        RX_CAPTURE = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                r_state;
    logic                  r_mode;
    logic                  r_chain_re;
    logic                  r_tx_irq;
    logic                  r_rx_irq;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_size;
    logic [GW-1:0]         r_gcnt;

    logic                  w_wr_ok;
    logic                  w_we_ok;
    logic                  w_tmo;
    logic [DATA_WIDTH-1:0] w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_rd_cnt;

    assign w_wr_ok   = bus.ahb_wr && !bus.fifo_full;
    assign w_we_ok   = bus.chain_we && !bus.fifo_full;
    assign w_cnt_inc = r_cnt + ONE;
    assign w_rd_cnt  = r_chain_re ? w_cnt_inc : r_cnt;

`ifdef WIFI_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          w_active;
    logic          w_progress;

    always_comb begin
        w_active   = (r_state == TX_LOAD) || (r_state == TX_STREAM) ||
                     (r_state == RX_CAPTURE);
        w_progress = ((r_state == TX_LOAD)    && w_wr_ok)    ||
                     ((r_state == TX_STREAM)  && r_chain_re) ||
                     ((r_state == RX_CAPTURE) && w_we_ok);
    end

    assign w_tmo = w_active && !w_progress &&
                   (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Phase changes only occur on counted words or exits to IDLE, so
    // clearing on progress and outside active states covers them.
    always_ff @(posedge hclk) begin
        if (!reset) begin
            r_tcnt <= '0;
        end else if (!w_active || w_progress) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge hclk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            r_chain_re <= 1'b0;
            r_tx_irq   <= 1'b0;
            r_rx_irq   <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_gcnt     <= '0;
        end else begin
            r_tx_irq <= 1'b0;
            r_rx_irq <= 1'b0;
            if (bus.abort) begin
                r_state    <= IDLE;
                r_chain_re <= 1'b0;
                r_cnt      <= '0;
            end else if (w_tmo) begin
                r_state    <= IDLE;
                r_err      <= 1'b1;
                r_chain_re <= 1'b0;
                r_cnt      <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.tx_start || bus.rx_start) begin
                            r_size  <= bus.data_size;
                            r_mode  <= bus.tx_start;
                            r_err   <= 1'b0;
                            r_cnt   <= '0;
                            r_gcnt  <= '0;
                            r_state <= GUARD;
                        end
                    end
                    GUARD: begin
                        if (r_gcnt == GLAST) begin
                            r_gcnt <= '0;
                            if (r_size == '0) begin
                                r_state  <= DONE;
                                r_tx_irq <= r_mode;
                                r_rx_irq <= !r_mode;
                            end else if (r_mode) begin
                                r_state <= TX_LOAD;
                            end else begin
                                r_state <= RX_CAPTURE;
                            end
                        end else begin
                            r_gcnt <= r_gcnt + 1'b1;
                        end
                    end
                    TX_LOAD: begin
                        if (w_wr_ok) begin
                            if (w_cnt_inc == r_size) begin
                                r_cnt   <= '0;
                                r_state <= TX_STREAM;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    TX_STREAM: begin
                        // The strobe issued last cycle is counted now.
                        r_cnt <= w_rd_cnt;
                        if (w_rd_cnt == r_size) begin
                            r_chain_re <= 1'b0;
                            r_tx_irq   <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_chain_re <= !bus.fifo_empty &&
                                          (w_rd_cnt < r_size);
                        end
                    end
                    RX_CAPTURE: begin
                        if (bus.chain_we && bus.fifo_full) begin
                            r_err <= 1'b1;
                        end else if (w_we_ok) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_size) begin
                                r_rx_irq <= 1'b1;
                                r_state  <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mode     = r_mode;
    assign bus.chain_re = r_chain_re;
    assign bus.tx_irq   = r_tx_irq;
    assign bus.rx_irq   = r_rx_irq;
    assign bus.busy     = (r_state != IDLE);
    assign bus.err      = r_err;
    assign bus.word_cnt = r_cnt;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_wifi_shared_mem_ctrl.sv
// Self-checking bench for wifi_shared_mem_ctrl; irq completions are
// checked against a queue of expected job types.
module tb_wifi_shared_mem_ctrl;
    localparam int DW = 32;
    localparam int GC = 4;
    localparam int TO = 16;

    logic hclk  = 1'b0;
    logic reset = 1'b0;
    always #5 hclk = ~hclk;

    wifi_shared_mem_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    wifi_shared_mem_ctrl #(
        .DATA_WIDTH    (DW),
        .GUARD_CYCLES  (GC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .hclk (hclk),
        .reset(reset),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    // Scoreboard: every irq pulse must match the next expected job type.
    always @(negedge hclk) begin
        if (reset && (bus.tx_irq || bus.rx_irq)) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL irq_unexpected got tx/rx=%b exp=none",
                         {bus.tx_irq, bus.rx_irq});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.tx_irq, bus.rx_irq} !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL irq_kind got tx/rx=%b exp=%b",
                             {bus.tx_irq, bus.rx_irq}, mon_exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic start_job(input logic tx, input logic rx,
                             input logic [DW-1:0] sz);
        bus.tx_start  = tx;
        bus.rx_start  = rx;
        bus.data_size = sz;
        cyc(1);
        bus.tx_start = 1'b0;
        bus.rx_start = 1'b0;
    endtask

    task automatic test_reset;
        bus.tx_start = 0; bus.rx_start = 0; bus.abort = 0;
        bus.data_size = '0; bus.fifo_full = 0; bus.fifo_empty = 1;
        bus.ahb_wr = 0; bus.chain_we = 0;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        tests_run++;
        if ({bus.state, bus.mode, bus.chain_re, bus.tx_irq, bus.rx_irq,
             bus.busy, bus.err} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0", {bus.state, bus.mode,
                     bus.chain_re, bus.tx_irq, bus.rx_irq, bus.busy, bus.err});
        end
        tests_run++;
        if (bus.word_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.word_cnt);
        end
        // Reset taken in the middle of a TX stream
        start_job(1, 0, 2);
        cyc(GC);
        bus.ahb_wr = 1;
        cyc(2);
        bus.ahb_wr = 0;
        tests_run++;
        if (bus.state !== 3'd3) begin
            tests_failed++;
            $display("FAIL reset_pre_stream got=%0d exp=3", bus.state);
        end
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        tests_run++;
        if ({bus.state, bus.mode, bus.chain_re, bus.tx_irq, bus.rx_irq,
             bus.busy, bus.err} !== 9'b0 || bus.word_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid got=%b cnt=%0d exp=0", {bus.state,
                     bus.mode, bus.chain_re, bus.busy, bus.err}, bus.word_cnt);
        end
    endtask

    task automatic test_tx;
        int n_re;
        bit done;
        exp_q.push_back(2'b10);
        start_job(1, 0, 3);
        tests_run++;
        if (bus.mode !== 1'b1 || bus.state !== 3'd1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_guard got mode=%b st=%0d exp mode=1 st=1",
                     bus.mode, bus.state);
        end
        cyc(GC - 1);
        tests_run++;
        if (bus.state !== 3'd1) begin
            tests_failed++;
            $display("FAIL tx_guard_len got=%0d exp=1", bus.state);
        end
        cyc(1);
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("FAIL tx_load_entry got=%0d exp=2", bus.state);
        end
        bus.ahb_wr = 1; bus.fifo_full = 1;
        cyc(1);
        bus.fifo_full = 0;
        tests_run++;
        if (bus.word_cnt !== 0) begin
            tests_failed++;
            $display("FAIL tx_full_wr got=%0d exp=0", bus.word_cnt);
        end
        cyc(2);
        tests_run++;
        if (bus.word_cnt !== 2) begin
            tests_failed++;
            $display("FAIL tx_load_cnt got=%0d exp=2", bus.word_cnt);
        end
        bus.fifo_empty = 1;
        cyc(1);
        bus.ahb_wr = 0;
        tests_run++;
        if (bus.state !== 3'd3 || bus.word_cnt !== 0) begin
            tests_failed++;
            $display("FAIL tx_stream_entry got st=%0d cnt=%0d exp st=3 cnt=0",
                     bus.state, bus.word_cnt);
        end
        cyc(2);
        tests_run++;
        if (bus.chain_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_empty_hold got=%b exp=0", bus.chain_re);
        end
        bus.fifo_empty = 0;
        n_re = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1);
            if (bus.chain_re) n_re++;
            if (bus.state == 3'd5) done = 1;
        end
        tests_run++;
        if (!done || n_re !== 3) begin
            tests_failed++;
            $display("FAIL tx_stream got done=%0d re=%0d exp done=1 re=3",
                     done, n_re);
        end
        tests_run++;
        if (bus.tx_irq !== 1'b1 || bus.rx_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_irq got=%b%b exp=10", bus.tx_irq, bus.rx_irq);
        end
        bus.fifo_empty = 1;
        cyc(1);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.tx_irq !== 1'b0 || bus.mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_end got busy=%b irq=%b mode=%b exp 0 0 1",
                     bus.busy, bus.tx_irq, bus.mode);
        end
    endtask

    task automatic test_rx_overflow;
        exp_q.push_back(2'b01);
        start_job(0, 1, 2);
        bus.tx_start = 1;
        cyc(1);
        bus.tx_start = 0;
        tests_run++;
        if (bus.mode !== 1'b0 || bus.state !== 3'd1) begin
            tests_failed++;
            $display("FAIL rx_ignore_start got mode=%b st=%0d exp 0 1",
                     bus.mode, bus.state);
        end
        cyc(GC - 1);
        tests_run++;
        if (bus.state !== 3'd4) begin
            tests_failed++;
            $display("FAIL rx_entry got=%0d exp=4", bus.state);
        end
        bus.chain_we = 1; bus.fifo_full = 1;
        cyc(1);
        bus.fifo_full = 0;
        tests_run++;
        if (bus.err !== 1'b1 || bus.word_cnt !== 0) begin
            tests_failed++;
            $display("FAIL rx_overflow got err=%b cnt=%0d exp 1 0",
                     bus.err, bus.word_cnt);
        end
        cyc(1);
        tests_run++;
        if (bus.word_cnt !== 1 || bus.state !== 3'd4) begin
            tests_failed++;
            $display("FAIL rx_cnt got cnt=%0d st=%0d exp 1 4",
                     bus.word_cnt, bus.state);
        end
        cyc(1);
        bus.chain_we = 0;
        tests_run++;
        if (bus.state !== 3'd5 || bus.rx_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_done got st=%0d irq=%b exp 5 1",
                     bus.state, bus.rx_irq);
        end
        cyc(1);
        tests_run++;
        if (bus.state !== 3'd0 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_sticky got st=%0d err=%b exp 0 1",
                     bus.state, bus.err);
        end
    endtask

    task automatic test_both_zero;
        exp_q.push_back(2'b10);
        start_job(1, 1, 0);
        tests_run++;
        if (bus.mode !== 1'b1 || bus.state !== 3'd1 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_start got mode=%b st=%0d err=%b exp 1 1 0",
                     bus.mode, bus.state, bus.err);
        end
        cyc(GC);
        tests_run++;
        if (bus.state !== 3'd5 || bus.tx_irq !== 1'b1 || bus.chain_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done got st=%0d irq=%b re=%b exp 5 1 0",
                     bus.state, bus.tx_irq, bus.chain_re);
        end
        cyc(1);
        tests_run++;
        if (bus.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL zero_idle got=%0d exp=0", bus.state);
        end
    endtask

    task automatic test_abort;
        start_job(1, 0, 5);
        cyc(GC);
        bus.ahb_wr = 1;
        cyc(1);
        tests_run++;
        if (bus.word_cnt !== 1) begin
            tests_failed++;
            $display("FAIL abort_pre got=%0d exp=1", bus.word_cnt);
        end
        bus.abort = 1; bus.rx_start = 1;
        cyc(1);
        bus.abort = 0; bus.rx_start = 0; bus.ahb_wr = 0;
        tests_run++;
        if (bus.state !== 3'd0 || bus.word_cnt !== 0 || bus.mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort got st=%0d cnt=%0d mode=%b exp 0 0 1",
                     bus.state, bus.word_cnt, bus.mode);
        end
        exp_q.push_back(2'b01);
        start_job(0, 1, 1);
        cyc(GC);
        tests_run++;
        if (bus.state !== 3'd4 || bus.mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_rx got st=%0d mode=%b exp 4 0",
                     bus.state, bus.mode);
        end
        bus.chain_we = 1;
        cyc(1);
        bus.chain_we = 0;
        tests_run++;
        if (bus.state !== 3'd5 || bus.rx_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_rx_done got st=%0d irq=%b exp 5 1",
                     bus.state, bus.rx_irq);
        end
        cyc(1);
    endtask

`ifdef WIFI_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        start_job(0, 1, 4);
        cyc(GC);
        cyc(TO - 1);
        tests_run++;
        if (bus.state !== 3'd4) begin
            tests_failed++;
            $display("FAIL tmo_early got=%0d exp=4", bus.state);
        end
        cyc(1);
        tests_run++;
        if (bus.state !== 3'd0 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo got st=%0d err=%b exp 0 1", bus.state, bus.err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tx();
        test_rx_overflow();
        test_both_zero();
        test_abort();
`ifdef WIFI_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        cyc(2);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL irq_missing got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
